// File: rtl/data_mem_ctrl.sv
// Load/store responder: one request at a time, drives a word-wide synchronous
// SRAM, builds byte enables and lane-replicated store data, and sign/zero
// extends load data. Misaligned or illegal-width requests answer with an error
// and never touch the SRAM.
module data_mem_ctrl #(
  parameter int ADDR_W       = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t      state;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [2:0]  lat_cnt;

  logic        req_err;
  logic [3:0]  req_be;
  logic [31:0] req_wrep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic        unused_addr_hi;

  assign req_ready      = (state == IDLE);
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Legality check of the incoming request: width code and alignment.
  always_comb begin
    req_err = 1'b0;
    if (req_write)
      req_err = (req_funct3 > 3'd2);
    else
      req_err = (req_funct3 == 3'd3) || (req_funct3 >= 3'd6);
    if (req_funct3[1:0] == 2'd1 && req_addr[0])
      req_err = 1'b1;
    if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0)
      req_err = 1'b1;
  end

  // Store byte enables and lane-replicated write data for the incoming request.
  always_comb begin
    req_be   = 4'b1111;
    req_wrep = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        req_be   = 4'b0001 << req_addr[1:0];
        req_wrep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        req_be   = 4'b0011 << req_addr[1:0];
        req_wrep = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be   = 4'b1111;
        req_wrep = req_wdata;
      end
    endcase
  end

  // Lane selection and extension of the returning SRAM word.
  always_comb begin
    ld_byte   = sram_rdata[{off_q, 3'b000} +: 8];
    ld_half   = sram_rdata[{off_q[1], 4'b0000} +: 16];
    load_data = sram_rdata;
    case (funct3_q[1:0])
      2'd0:    load_data = funct3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    load_data = funct3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = sram_rdata;
    endcase
  end

  // Request/response sequencing with registered SRAM and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      sram_en    <= 1'b0;
      sram_we    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      write_q    <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            funct3_q  <= req_funct3;
            off_q     <= req_addr[1:0];
            sram_addr <= req_addr[ADDR_W+1:2];
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else begin
              sram_en    <= 1'b1;
              sram_we    <= req_write ? req_be : 4'b0000;
              sram_wdata <= req_wrep;
              state      <= ACCESS;
            end
          end
        end
        ACCESS: begin
          sram_en <= 1'b0;
          sram_we <= '0;
          if (write_q) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            state      <= RESP;
          end else begin
            lat_cnt <= 3'(READ_LATENCY);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 3'd1) begin
            resp_rdata <= load_data;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
          lat_cnt <= lat_cnt - 3'd1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (read latency 1 and 3) share stimulus,
// one is selected at a time. A timestamp-based transaction model predicts every
// output each cycle; per-request literal values pin the model.
module tb_data_mem_ctrl;

  typedef struct {
    logic        err;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          lat;
  } pred_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic resp_ready = 1'b1;
  logic sel = 1'b0;
  logic tmo = 1'b0;

  logic [1:0] valid_g, ready_o, rvalid_o, rerr_o, en_o;
  logic [1:0][31:0] rdata_o, wd_o, srd;
  logic [1:0][3:0] we_o;
  logic [1:0][11:0] addr_o;
  logic [1:0][7:0][31:0] pd = '0;
  logic [1:0][7:0] pv = '0;

  logic cur_ready, cur_rvalid, cur_rerr, cur_en;
  logic [31:0] cur_rdata, cur_wd;
  logic [3:0] cur_we;
  logic [11:0] cur_addr;

  logic [31:0] lit_rdata = '0, lit_wd = '0;
  logic lit_err = 1'b0;
  logic [3:0] lit_we = '0;
  logic [11:0] lit_addr = '0;

  pred_t m;
  logic busy = 1'b0;
  logic m_wr = 1'b0;
  logic [11:0] m_addr = '0;
  int cyc = 0, en_c = 0, resp_c = 0;
  logic ev, ee;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign valid_g[0] = req_valid & ~sel;
  assign valid_g[1] = req_valid & sel;
  assign cur_ready  = ready_o[sel];
  assign cur_rvalid = rvalid_o[sel];
  assign cur_rerr   = rerr_o[sel];
  assign cur_en     = en_o[sel];
  assign cur_rdata  = rdata_o[sel];
  assign cur_wd     = wd_o[sel];
  assign cur_we     = we_o[sel];
  assign cur_addr   = addr_o[sel];

  data_mem_ctrl #(.ADDR_W(12), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(valid_g[0]), .req_ready(ready_o[0]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rvalid_o[0]), .resp_ready(resp_ready),
    .resp_rdata(rdata_o[0]), .resp_error(rerr_o[0]), .sram_en(en_o[0]),
    .sram_we(we_o[0]), .sram_addr(addr_o[0]), .sram_wdata(wd_o[0]),
    .sram_rdata(srd[0])
  );

  data_mem_ctrl #(.ADDR_W(12), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(valid_g[1]), .req_ready(ready_o[1]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rvalid_o[1]), .resp_ready(resp_ready),
    .resp_rdata(rdata_o[1]), .resp_error(rerr_o[1]), .sram_en(en_o[1]),
    .sram_we(we_o[1]), .sram_addr(addr_o[1]), .sram_wdata(wd_o[1]),
    .sram_rdata(srd[1])
  );

  // Fixed SRAM contents, indexed by the low word-address bits.
  function automatic logic [31:0] mem_word(input logic [3:0] i);
    case (i)
      4'd4:    return 32'hDEADBEEF;
      4'd5:    return 32'h80FF7F01;
      default: return {8'hC0, 4'h0, i, 16'h5A5A};
    endcase
  endfunction

  // SRAM models: read data valid exactly READ_LATENCY cycles after the enable cycle.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pd[k][0] <= mem_word(addr_o[k][3:0]);
      pv[k][0] <= en_o[k] & (we_o[k] == 4'b0000);
      for (int j = 1; j < 8; j++) begin
        pd[k][j] <= pd[k][j-1];
        pv[k][j] <= pv[k][j-1];
      end
    end
  end
  assign srd[0] = pv[0][0] ? pd[0][0] : 32'h5A5A5A5A;
  assign srd[1] = pv[1][2] ? pd[1][2] : 32'h5A5A5A5A;

  function automatic pred_t predict(input logic wr, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] wd, input int rl);
    pred_t p;
    int size, nb, off;
    logic [31:0] w, mask;
    size = int'(f3[1:0]);
    off  = int'(a[1:0]);
    nb   = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    p.err = (wr && f3 > 3'd2) || (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
            (size == 1 && off % 2 != 0) || (size == 2 && off != 0);
    p.we = '0; p.wd = '0; p.rdata = '0;
    if (!p.err && wr)
      for (int lane = 0; lane < 4; lane++) begin
        p.wd[8*lane +: 8] = wd[8*(lane % nb) +: 8];
        if (lane >= off && lane < off + nb) p.we[lane] = 1'b1;
      end
    if (!p.err && !wr) begin
      w = mem_word(a[5:2]) >> (8 * off);
      mask = (nb == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * nb)) - 32'h1);
      p.rdata = w & mask;
      if (!f3[2] && nb < 4 && p.rdata[8*nb-1]) p.rdata = p.rdata | ~mask;
    end
    p.lat = p.err ? 1 : (wr ? 2 : 2 + rl);
    return p;
  endfunction

  // Transaction model: accept, predicted response time, retire on handshake.
  initial forever begin
    @(posedge clk);
    if (reset) busy = 1'b0;
    else if (busy) begin
      if (cyc >= resp_c && resp_ready) busy = 1'b0;
    end else if (req_valid) begin
      m      = predict(req_write, req_funct3, req_addr, req_wdata, sel ? 3 : 1);
      m_wr   = req_write;
      m_addr = req_addr[13:2];
      en_c   = cyc + 1;
      resp_c = cyc + m.lat;
      busy   = 1'b1;
    end
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare process: every cycle, on the falling edge.
  initial forever begin
    @(negedge clk);
    ev = busy && (cyc >= resp_c);
    ee = busy && !m.err && (cyc == en_c);
    if (reset) begin
      chk("rst_req_ready", 32'(cur_ready), 32'd1);
      chk("rst_resp_valid", 32'(cur_rvalid), 32'd0);
      chk("rst_resp_error", 32'(cur_rerr), 32'd0);
      chk("rst_sram_en", 32'(cur_en), 32'd0);
      chk("rst_sram_we", 32'(cur_we), 32'd0);
      chk("rst_resp_rdata", cur_rdata, 32'd0);
      chk("rst_sram_addr", 32'(cur_addr), 32'd0);
      chk("rst_sram_wdata", cur_wd, 32'd0);
    end else begin
      chk("req_ready", 32'(cur_ready), 32'(!busy));
      chk("resp_valid", 32'(cur_rvalid), 32'(ev));
      chk("resp_error", 32'(cur_rerr), 32'(ev && m.err));
      chk("sram_en", 32'(cur_en), 32'(ee));
      chk("sram_we", 32'(cur_we), ee ? 32'(m.we) : 32'd0);
      if (ev) begin
        chk("resp_rdata", cur_rdata, m.rdata);
        chk("lit_rdata", cur_rdata, lit_rdata);
        chk("lit_error", 32'(cur_rerr), 32'(lit_err));
      end
      if (ee) begin
        chk("sram_addr", 32'(cur_addr), 32'(m_addr));
        chk("lit_sram_addr", 32'(cur_addr), 32'(lit_addr));
        chk("lit_sram_we", 32'(cur_we), 32'(lit_we));
        if (m_wr) begin
          chk("sram_wdata", cur_wd, m.wd);
          chk("lit_sram_wdata", cur_wd, lit_wd);
        end
      end
    end
    chk("wait_bound", 32'(tmo), 32'd0);
  end

  task automatic wait_resp();
    int n;
    n = 0;
    while (!cur_rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) tmo = 1'b1;
  endtask

  task automatic set_lit(input logic [31:0] lrd, input logic lerr, input logic [3:0] lwe,
                         input logic [11:0] laddr, input logic [31:0] lwd);
    lit_rdata = lrd; lit_err = lerr; lit_we = lwe; lit_addr = laddr; lit_wd = lwd;
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] lrd, input logic lerr,
                       input logic [3:0] lwe, input logic [11:0] laddr, input logic [31:0] lwd);
    int n;
    n = 0;
    while (!cur_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) tmo = 1'b1;
    set_lit(lrd, lerr, lwe, laddr, lwd);
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Read latency 1: word load and sign handling
    issue(1'b0, 3'd2, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0, 4'b0000, 12'h004, 32'h0);
    issue(1'b0, 3'd0, 32'h14,  32'h0, 32'h00000001, 1'b0, 4'b0000, 12'h005, 32'h0);
    issue(1'b0, 3'd0, 32'h15,  32'h0, 32'h0000007F, 1'b0, 4'b0000, 12'h005, 32'h0);
    issue(1'b0, 3'd0, 32'h16,  32'h0, 32'hFFFFFFFF, 1'b0, 4'b0000, 12'h005, 32'h0);
    issue(1'b0, 3'd0, 32'h17,  32'h0, 32'hFFFFFF80, 1'b0, 4'b0000, 12'h005, 32'h0);
    issue(1'b0, 3'd4, 32'h17,  32'h0, 32'h00000080, 1'b0, 4'b0000, 12'h005, 32'h0);
    issue(1'b0, 3'd1, 32'h14,  32'h0, 32'h00007F01, 1'b0, 4'b0000, 12'h005, 32'h0);
    issue(1'b0, 3'd1, 32'h16,  32'h0, 32'hFFFF80FF, 1'b0, 4'b0000, 12'h005, 32'h0);
    issue(1'b0, 3'd5, 32'h16,  32'h0, 32'h000080FF, 1'b0, 4'b0000, 12'h005, 32'h0);
    // Stores
    issue(1'b1, 3'd0, 32'h102, 32'h000000AB, 32'h0, 1'b0, 4'b0100, 12'h040, 32'hABABABAB);
    issue(1'b1, 3'd1, 32'h102, 32'h00001234, 32'h0, 1'b0, 4'b1100, 12'h040, 32'h12341234);
    issue(1'b1, 3'd2, 32'h104, 32'hCAFEF00D, 32'h0, 1'b0, 4'b1111, 12'h041, 32'hCAFEF00D);
    issue(1'b1, 3'd0, 32'h0,   32'h12345667, 32'h0, 1'b0, 4'b0001, 12'h000, 32'h67676767);
    // Errors
    issue(1'b0, 3'd2, 32'h6,   32'h0, 32'h0, 1'b1, 4'b0000, 12'h000, 32'h0);
    issue(1'b1, 3'd1, 32'h3,   32'hFFFF, 32'h0, 1'b1, 4'b0000, 12'h000, 32'h0);
    issue(1'b0, 3'd3, 32'h0,   32'h0, 32'h0, 1'b1, 4'b0000, 12'h000, 32'h0);
    issue(1'b0, 3'd6, 32'h0,   32'h0, 32'h0, 1'b1, 4'b0000, 12'h000, 32'h0);
    issue(1'b0, 3'd7, 32'h0,   32'h0, 32'h0, 1'b1, 4'b0000, 12'h000, 32'h0);
    issue(1'b1, 3'd4, 32'h0,   32'h0, 32'h0, 1'b1, 4'b0000, 12'h000, 32'h0);
    issue(1'b0, 3'd5, 32'h15,  32'h0, 32'h0, 1'b1, 4'b0000, 12'h000, 32'h0);
    issue(1'b1, 3'd2, 32'h2,   32'h0, 32'h0, 1'b1, 4'b0000, 12'h000, 32'h0);

    // Read latency 3 with response backpressure and an ignored second request
    sel = 1'b1;
    @(posedge clk); #1;
    set_lit(32'hDEADBEEF, 1'b0, 4'b0000, 12'h004, 32'h0);
    resp_ready = 1'b0;
    req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp();
    req_funct3 = 3'd0; req_addr = 32'h15; req_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 3'd0, 32'h17, 32'h0, 32'hFFFFFF80, 1'b0, 4'b0000, 12'h005, 32'h0);
    issue(1'b0, 3'd5, 32'h16, 32'h0, 32'h000080FF, 1'b0, 4'b0000, 12'h005, 32'h0);

    // Reset while waiting on read data, then a normal load
    set_lit(32'h80FF7F01, 1'b0, 4'b0000, 12'h005, 32'h0);
    req_funct3 = 3'd2; req_addr = 32'h14; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    issue(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000, 12'h004, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Responder side of the pipeline's load/store request interface. Accepts one memory request at a time from the execute/memory stage and drives a word-wide synchronous data SRAM.
- Generates byte enables for SB/SH/SW and extracts plus sign/zero-extends load data for LB/LH/LW/LBU/LHU.
- Returns a single response per request: load data, or a store acknowledge, or a misalignment/illegal-width error.

Parameters:
- ADDR_W, 12, width of the SRAM word address (capacity is 4 * 2^ADDR_W bytes).
- READ_LATENCY, 1, cycles from the SRAM enable cycle until sram_rdata is valid. Legal range is 1..7.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  `MEM_REQ_WRITE` = store, `MEM_REQ_READ` = load.
- req_funct3  input  3  RV32I width/sign field taken from inst[14:12].
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  request was misaligned or had an illegal funct3; no SRAM access was made.
- sram_en  output  1  SRAM access strobe.
- sram_we  output  4  byte write enables; 0 on reads.
- sram_addr  output  ADDR_W  word address, equal to req_addr[ADDR_W+1:2].
- sram_wdata  output  32  lane-replicated store data.
- sram_rdata  input  32  SRAM read data.

Behaviour:
- FSM states: IDLE, ACCESS, WAIT, RESP.
  - req_ready = (state == IDLE), decoded combinationally from state.
  - All other outputs are registered.
- Reset (asynchronous, any state): state goes to IDLE. resp_valid, resp_error, sram_en go to 0. sram_we goes to 4'b0. resp_rdata, sram_addr, sram_wdata go to 0. req_ready is therefore 1. Reset mid-transaction aborts it: no response is produced and sram_en drops immediately.
- IDLE, req_valid=1 (accept at cycle T): capture write flag, funct3, addr[1:0], wdata.
  - Error check:
    - Loads: funct3 3, 6, 7 are illegal.
    - Stores: funct3 above 2 is illegal.
    - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - On error: go to RESP with resp_error=1 and resp_rdata=0. The SRAM is never enabled. Response appears at T+1.
  - Otherwise: go to ACCESS.
- ACCESS (cycle T+1): sram_en=1 for exactly this one cycle.
  - Store byte enables:
    - SB: 4'b0001 << addr[1:0].
    - SH: 4'b0011 << addr[1:0].
    - SW: 4'b1111.
  - sram_wdata: SB replicates wdata[7:0] into all 4 lanes; SH replicates wdata[15:0] into both halves; SW passes wdata through.
  - Store: go to RESP; response at T+2 with resp_rdata=0.
  - Load: load the latency counter with READ_LATENCY and go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle where the counter equals 1, capture sram_rdata and go to RESP. Load response appears at T+2+READ_LATENCY.
- Load extraction:
  - Byte lane is addr[1:0]; halfword lane is addr[1].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- RESP: resp_valid=1, with resp_rdata and resp_error stable. Hold until resp_ready=1; on that edge clear resp_valid and resp_error and go to IDLE.
- resp_ready=1 in the same cycle resp_valid rises completes the handshake on that edge.
- One outstanding request at most. A new request is not accepted in the cycle the response retires; the earliest next accept is the following cycle.
- req_valid outside IDLE is ignored. The requester must hold the request until req_ready is high.
- resp_ready while resp_valid=0 has no effect.

Test Plan:
- LW at addr 0x00000010, READ_LATENCY=1, sram_rdata=0xDEADBEEF, resp_ready held 1 -> sram_en=1 at T+1 with sram_addr=4, sram_we=0; resp_valid at T+3 with resp_rdata=0xDEADBEEF, resp_error=0.
- Sign handling with sram_rdata=0x80FF7F01, repeated at addr offsets 0..3 -> LB@1=0x0000007F, LB@3=0xFFFFFF80, LBU@3=0x00000080, LH@2=0xFFFF80FF, LHU@2=0x000080FF.
- SB wdata=0x000000AB at addr 0x102, then SH wdata=0x1234 at addr 0x102 -> sram_we=4'b0100 with sram_wdata=0xABABABAB; then sram_we=4'b1100 with sram_wdata=0x12341234. Each resp_valid at T+2 with resp_rdata=0.
- Errors: LW at addr 0x6, SH at addr 0x3, and load with funct3=3 -> resp_error=1 at T+1, resp_rdata=0, sram_en never asserted.
- Backpressure: READ_LATENCY=3, resp_ready=0 for 5 cycles after resp_valid -> resp_valid and resp_rdata held constant, req_ready=0, a second req_valid is ignored; after resp_ready=1, req_ready=1 the next cycle.
- Reset asserted during WAIT -> state IDLE immediately, sram_en=0, no resp_valid after release; next LW completes normally.
